// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: decoded-instruction, forwarding and EX-output bundle between ID/EX control and the ID/EX stage
interface id_ex_stage_if #(
    parameter int DW   = 32,
    parameter int RW   = 5,
    parameter int CNTW = 16
);
    logic            flush;
    logic            id_valid;
    logic [3:0]      id_aluop;
    logic [RW-1:0]   id_rs;
    logic [RW-1:0]   id_rt;
    logic            id_uses_rt;
    logic [RW-1:0]   id_rd;
    logic [DW-1:0]   id_rs_data;
    logic [DW-1:0]   id_rt_data;
    logic [DW-1:0]   id_imm;
    logic            id_alusrc;
    logic            id_memread;
    logic            id_memwrite;
    logic            id_regwrite;
    logic            exmem_regwrite;
    logic [RW-1:0]   exmem_rd;
    logic [DW-1:0]   exmem_result;
    logic            memwb_regwrite;
    logic [RW-1:0]   memwb_rd;
    logic [DW-1:0]   memwb_result;
    logic            stall;
    logic            ex_valid;
    logic [3:0]      ex_aluop;
    logic [DW-1:0]   ex_a;
    logic [DW-1:0]   ex_b;
    logic [DW-1:0]   ex_store_data;
    logic [RW-1:0]   ex_rd;
    logic            ex_memread;
    logic            ex_memwrite;
    logic            ex_regwrite;
    logic [CNTW-1:0] stall_count;

    modport master (
        output flush, id_valid, id_aluop, id_rs, id_rt, id_uses_rt, id_rd,
               id_rs_data, id_rt_data, id_imm, id_alusrc, id_memread, id_memwrite, id_regwrite,
               exmem_regwrite, exmem_rd, exmem_result, memwb_regwrite, memwb_rd, memwb_result,
        input  stall, ex_valid, ex_aluop, ex_a, ex_b, ex_store_data, ex_rd,
               ex_memread, ex_memwrite, ex_regwrite, stall_count
    );

    modport slave (
        input  flush, id_valid, id_aluop, id_rs, id_rt, id_uses_rt, id_rd,
               id_rs_data, id_rt_data, id_imm, id_alusrc, id_memread, id_memwrite, id_regwrite,
               exmem_regwrite, exmem_rd, exmem_result, memwb_regwrite, memwb_rd, memwb_result,
        output stall, ex_valid, ex_aluop, ex_a, ex_b, ex_store_data, ex_rd,
               ex_memread, ex_memwrite, ex_regwrite, stall_count
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with lw load-use stall detection, EX operand forwarding and a saturating stall counter
module id_ex_stage #(
    parameter int DW   = 32,
    parameter int RW   = 5,
    parameter int CNTW = 16
) (
    input logic          clk,
    input logic          reset,
    id_ex_stage_if.slave bus
);
    localparam logic [3:0] ALU_PASS_A = 4'b1010;
    logic            valid_q, memread_q, memwrite_q, regwrite_q, alusrc_q;
    logic [3:0]      aluop_q;
    logic [RW-1:0]   rd_q, rs_q, rt_q;
    logic [DW-1:0]   rs_data_q, rt_data_q, imm_q;
    logic [CNTW-1:0] cnt_q;
    logic            hazard, stall, load;
    logic [DW-1:0]   rs_fwd, rt_fwd;
    always_comb begin
        hazard = valid_q && memread_q && rd_q != '0 &&
                 (rd_q == bus.id_rs || (bus.id_uses_rt && rd_q == bus.id_rt));
        stall  = bus.id_valid && hazard && !bus.flush;
        load   = bus.id_valid && !bus.flush && !stall;
    end
    // Register 0 is hardwired to zero, so it never takes a forwarded value.
    always_comb begin
        rs_fwd = rs_q == '0 ? rs_data_q :
                 bus.exmem_regwrite && bus.exmem_rd == rs_q ? bus.exmem_result :
                 bus.memwb_regwrite && bus.memwb_rd == rs_q ? bus.memwb_result : rs_data_q;
        rt_fwd = rt_q == '0 ? rt_data_q :
                 bus.exmem_regwrite && bus.exmem_rd == rt_q ? bus.exmem_result :
                 bus.memwb_regwrite && bus.memwb_rd == rt_q ? bus.memwb_result : rt_data_q;
    end
    // Bubbles clear only control; data fields keep their old contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q    <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            regwrite_q <= 1'b0;
            alusrc_q   <= 1'b0;
            aluop_q    <= ALU_PASS_A;
            rd_q       <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            rs_data_q  <= '0;
            rt_data_q  <= '0;
            imm_q      <= '0;
        end else if (load) begin
            valid_q    <= 1'b1;
            memread_q  <= bus.id_memread;
            memwrite_q <= bus.id_memwrite;
            regwrite_q <= bus.id_regwrite;
            alusrc_q   <= bus.id_alusrc;
            aluop_q    <= bus.id_aluop;
            rd_q       <= bus.id_rd;
            rs_q       <= bus.id_rs;
            rt_q       <= bus.id_rt;
            rs_data_q  <= bus.id_rs_data;
            rt_data_q  <= bus.id_rt_data;
            imm_q      <= bus.id_imm;
        end else begin
            valid_q    <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            regwrite_q <= 1'b0;
            aluop_q    <= ALU_PASS_A;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else if (stall && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end
    assign bus.stall         = stall;
    assign bus.ex_valid      = valid_q;
    assign bus.ex_aluop      = aluop_q;
    assign bus.ex_a          = rs_fwd;
    assign bus.ex_b          = alusrc_q ? imm_q : rt_fwd;
    assign bus.ex_store_data = rt_fwd;
    assign bus.ex_rd         = rd_q;
    assign bus.ex_memread    = memread_q;
    assign bus.ex_memwrite   = memwrite_q;
    assign bus.ex_regwrite   = regwrite_q;
    assign bus.stall_count   = cnt_q;
endmodule
